// File: rtl/sweep_pkg.sv
// Shared types and constants for the sweep controller and its step checker.
package sweep_pkg;

  localparam int CNT_W   = 10;
  localparam int STEP_UP = 5;
  localparam int STEP_DN = 9;
  localparam int CNT_INV = -11;
  localparam int CNT_RST = -50;

  typedef logic signed [CNT_W-1:0] cnt_t;

  typedef enum logic [2:0] {
    IDLE,
    UP,
    DWELL_HI,
    DOWN,
    DWELL_LO
  } state_t;

endpackage

// File: rtl/sweep_step_chk.sv
// Counter delta legality checker: compares each new cnt sample against the
// previous one and raises a one-cycle err when the step is not one the
// counter can legally make (including the skip over the forbidden value).
module sweep_step_chk
  import sweep_pkg::*;
#(
  parameter int HI_THR = 231,
  parameter int LO_THR = -222
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [CNT_W-1:0] cnt,
  input  logic                    mode,
  input  logic                    run,
  output logic signed [CNT_W-1:0] cnt_q,
  output logic                    err
);

  typedef logic signed [CNT_W:0] dlt_t;

  localparam cnt_t HI_C  = cnt_t'(HI_THR);
  localparam cnt_t LO_C  = cnt_t'(LO_THR);
  localparam cnt_t INV_C = cnt_t'(CNT_INV);

  logic mode_q;
  logic chk_v;
  dlt_t delta;
  logic in_band;
  logic legal;

  // Capture last cnt/mode and whether the previous cycle was actively counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= cnt_t'(CNT_RST);
      mode_q <= 1'b1;
      chk_v  <= 1'b0;
    end else begin
      cnt_q  <= cnt;
      mode_q <= mode;
      chk_v  <= run;
    end
  end

  // Judge the delta only inside the unsaturated band; -11 is always illegal.
  always_comb begin
    delta   = dlt_t'(cnt) - dlt_t'(cnt_q);
    in_band = (cnt > LO_C) && (cnt < HI_C);
    legal   = 1'b0;
    if (mode_q) begin
      legal = (delta == dlt_t'(STEP_UP)) || (delta == dlt_t'(2 * STEP_UP));
    end else begin
      legal = (delta == dlt_t'(-STEP_DN)) || (delta == dlt_t'(-2 * STEP_DN));
    end
    err = (chk_v && in_band && !legal) || (cnt == INV_C);
  end

endmodule

// File: rtl/sweep_mode_ctrl.sv
// Triangle-sweep controller for the signed up/down counter: drives mode,
// dwells at each saturation band, counts sweeps and flags bad or stalled steps.
module sweep_mode_ctrl
  import sweep_pkg::*;
#(
  parameter int HI_THR     = 231,
  parameter int LO_THR     = -222,
  parameter int DWELL      = 4,
  parameter int NUM_SWEEPS = 0,
  parameter int STALL_MAX  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    abort,
  input  logic signed [CNT_W-1:0] cnt,
  output logic                    mode,
  output logic                    busy,
  output logic [7:0]              sweeps,
  output logic                    done,
  output logic                    err_step,
  output logic                    err_stall
);

  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int SW_W = (STALL_MAX > 1) ? $clog2(STALL_MAX) : 1;
  localparam logic [DW_W-1:0] DWELL_LD   = DW_W'(DWELL - 1);
  localparam logic [SW_W-1:0] STALL_LAST = SW_W'(STALL_MAX - 1);
  localparam logic [7:0]      SWEEP_GOAL = 8'(NUM_SWEEPS);
  localparam cnt_t            HI_C       = cnt_t'(HI_THR);
  localparam cnt_t            LO_C       = cnt_t'(LO_THR);

  state_t          state, state_n;
  logic            mode_n, busy_n, done_n, err_stall_n;
  logic [7:0]      sweeps_n, sweeps_inc;
  logic            stop_pend, stop_pend_n;
  logic [DW_W-1:0] dwell_cnt, dwell_n;
  logic [SW_W-1:0] stall_cnt, stall_n;
  logic            run, clear, step_err;
  cnt_t            cnt_q;

  assign run = (state == UP) || (state == DOWN);

  sweep_step_chk #(
    .HI_THR(HI_THR),
    .LO_THR(LO_THR)
  ) u_step_chk (
    .clk  (clk),
    .rst  (rst),
    .cnt  (cnt),
    .mode (mode),
    .run  (run),
    .cnt_q(cnt_q),
    .err  (step_err)
  );

  // Register state and every output so downstream sees clean levels.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mode      <= 1'b1;
      busy      <= 1'b0;
      sweeps    <= 8'd0;
      done      <= 1'b0;
      err_step  <= 1'b0;
      err_stall <= 1'b0;
      stop_pend <= 1'b0;
      dwell_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      state     <= state_n;
      mode      <= mode_n;
      busy      <= busy_n;
      sweeps    <= sweeps_n;
      done      <= done_n;
      err_step  <= (err_step & ~clear) | step_err;
      err_stall <= err_stall_n;
      stop_pend <= stop_pend_n;
      dwell_cnt <= dwell_n;
      stall_cnt <= stall_n;
    end
  end

  // Next-state logic; stall detection overrides the sweep, abort overrides all.
  always_comb begin
    state_n     = state;
    mode_n      = mode;
    sweeps_n    = sweeps;
    done_n      = 1'b0;
    err_stall_n = err_stall;
    stop_pend_n = stop_pend;
    dwell_n     = dwell_cnt;
    stall_n     = stall_cnt;
    clear       = 1'b0;
    sweeps_inc  = (sweeps == 8'd255) ? sweeps : sweeps + 8'd1;

    if (state != IDLE && stop) stop_pend_n = 1'b1;
    if (run) stall_n = (cnt == cnt_q) ? stall_cnt + 1'b1 : '0;

    case (state)
      IDLE: begin
        if (start) begin
          state_n     = UP;
          mode_n      = 1'b1;
          sweeps_n    = 8'd0;
          err_stall_n = 1'b0;
          stop_pend_n = 1'b0;
          clear       = 1'b1;
        end
      end
      UP: begin
        mode_n = 1'b1;
        if (cnt >= HI_C) begin
          state_n = DWELL_HI;
          dwell_n = DWELL_LD;
        end
      end
      DWELL_HI: begin
        if (dwell_cnt == '0) begin
          state_n = DOWN;
          mode_n  = 1'b0;
        end else begin
          dwell_n = dwell_cnt - 1'b1;
        end
      end
      DOWN: begin
        mode_n = 1'b0;
        if (cnt <= LO_C) begin
          state_n = DWELL_LO;
          dwell_n = DWELL_LD;
        end
      end
      DWELL_LO: begin
        if (dwell_cnt == '0) begin
          sweeps_n = sweeps_inc;
          mode_n   = 1'b1;
          if (stop_pend || (NUM_SWEEPS != 0 && sweeps_inc == SWEEP_GOAL)) begin
            state_n     = IDLE;
            done_n      = 1'b1;
            stop_pend_n = 1'b0;
          end else begin
            state_n = UP;
          end
        end else begin
          dwell_n = dwell_cnt - 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        mode_n  = 1'b1;
      end
    endcase

    if (run && cnt == cnt_q && stall_cnt == STALL_LAST) begin
      err_stall_n = 1'b1;
      state_n     = IDLE;
      mode_n      = 1'b1;
    end

    if (abort) begin
      state_n     = IDLE;
      mode_n      = 1'b1;
      stop_pend_n = 1'b0;
      done_n      = 1'b0;
      sweeps_n    = sweeps;
      err_stall_n = err_stall;
      clear       = 1'b0;
    end

    if (state_n != state) stall_n = '0;
    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_sweep_mode_ctrl.sv
// Directed bench for sweep_mode_ctrl with a saturating +5/-9 counter model
// (skipping -11) in the loop, plus an injection path for hand-picked cnt values.
module tb_sweep_mode_ctrl;

  logic              clk = 1'b0;
  logic              rst, start, stop, abort;
  logic              inject, cnt_run;
  logic signed [9:0] cnt_inj, cnt_model, cnt;
  logic              mode, busy, done, err_step, err_stall;
  logic [7:0]        sweeps;
  int                n_checks = 0;
  int                n_fail   = 0;
  int                n;

  assign cnt = inject ? cnt_inj : cnt_model;

  sweep_mode_ctrl #(
    .HI_THR(231), .LO_THR(-222), .DWELL(4), .NUM_SWEEPS(2), .STALL_MAX(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .abort(abort), .cnt(cnt),
    .mode(mode), .busy(busy), .sweeps(sweeps), .done(done),
    .err_step(err_step), .err_stall(err_stall)
  );

  always #5 clk = ~clk;

  // Attached counter: saturates at the bands and steps over -11.
  function automatic logic signed [9:0] ctr_next(input logic signed [9:0] c, input logic m);
    logic signed [9:0] r;
    if (m) begin
      if (c >= 10'sd231) r = c;
      else begin
        r = c + 10'sd5;
        if (r == -10'sd11) r = -10'sd6;
      end
    end else begin
      if (c <= -10'sd222) r = c;
      else begin
        r = c - 10'sd9;
        if (r == -10'sd11) r = -10'sd20;
      end
    end
    return r;
  endfunction

  // Counter model advances on every clock with the DUT's current mode.
  always @(posedge clk) begin
    if (rst || !cnt_run) cnt_model <= -10'sd50;
    else cnt_model <= ctr_next(cnt_model, mode);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic p, input logic a);
    start = s;
    stop  = p;
    abort = a;
  endtask

  task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic waitMode(input logic val, input int budget, output int cyc);
    cyc = 0;
    while (mode !== val && cyc < budget) begin
      tick();
      cyc++;
    end
  endtask

  task automatic waitDone(input int budget, output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < budget) begin
      tick();
      cyc++;
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_mode"}, 32'(mode), 1);
    checkOutput({tag, "_busy"}, 32'(busy), 0);
    checkOutput({tag, "_sweeps"}, 32'(sweeps), 0);
    checkOutput({tag, "_done"}, 32'(done), 0);
    checkOutput({tag, "_err_step"}, 32'(err_step), 0);
    checkOutput({tag, "_err_stall"}, 32'(err_stall), 0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(0, 0, 0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; inject = 1'b0; cnt_run = 1'b0; cnt_inj = '0;
    applyStimulus(0, 0, 0);
    tick();
    tick();
    checkResetState("reset");

    // Full sweep with the counter attached
    $display("[TB] sweep with attached counter");
    rst = 1'b0; cnt_run = 1'b1;
    applyStimulus(1, 0, 0);
    tick();
    applyStimulus(0, 0, 0);
    checkOutput("start_busy", 32'(busy), 1);
    checkOutput("start_mode", 32'(mode), 1);
    waitMode(1'b0, 200, n);
    checkOutput("up_dwell_hi_cycles", n, 61);
    waitMode(1'b1, 200, n);
    checkOutput("down_dwell_lo_cycles", n, 56);
    checkOutput("sweep1_count", 32'(sweeps), 1);
    checkOutput("sweep1_busy", 32'(busy), 1);
    repeat (93) tick();
    checkOutput("dwell_hi2_mode", 32'(mode), 1);
    checkOutput("dwell_hi2_busy", 32'(busy), 1);

    // Reset while dwelling at the top band
    rst = 1'b1;
    tick();
    checkResetState("midrst");
    rst = 1'b0;
    applyStimulus(1, 0, 0);
    tick();
    applyStimulus(0, 0, 0);
    checkOutput("restart_busy", 32'(busy), 1);
    checkOutput("restart_sweeps", 32'(sweeps), 0);
    waitMode(1'b0, 200, n);
    checkOutput("restart_up_cycles", n, 61);
    waitMode(1'b1, 200, n);
    checkOutput("restart_down_cycles", n, 56);
    checkOutput("restart_sweep1", 32'(sweeps), 1);
    waitDone(400, n);
    checkOutput("sweep2_done_cycles", n, 152);
    checkOutput("sweep2_count", 32'(sweeps), 2);
    checkOutput("sweep2_busy", 32'(busy), 0);
    checkOutput("sweep2_mode", 32'(mode), 1);
    checkOutput("sweep2_err_step", 32'(err_step), 0);
    checkOutput("sweep2_err_stall", 32'(err_stall), 0);
    tick();
    checkOutput("done_one_cycle", 32'(done), 0);

    // Graceful stop requested mid-UP
    $display("[TB] graceful stop");
    doReset();
    applyStimulus(1, 0, 0);
    tick();
    applyStimulus(0, 0, 0);
    repeat (10) tick();
    applyStimulus(0, 1, 0);
    tick();
    applyStimulus(0, 0, 0);
    waitDone(400, n);
    checkOutput("stop_done_cycles", n, 106);
    checkOutput("stop_sweeps", 32'(sweeps), 1);
    checkOutput("stop_busy", 32'(busy), 0);

    // Abort mid-DOWN
    $display("[TB] abort");
    doReset();
    applyStimulus(1, 0, 0);
    tick();
    applyStimulus(0, 0, 0);
    waitMode(1'b0, 200, n);
    repeat (5) tick();
    applyStimulus(0, 0, 1);
    tick();
    applyStimulus(0, 0, 0);
    checkOutput("abort_busy", 32'(busy), 0);
    checkOutput("abort_mode", 32'(mode), 1);
    checkOutput("abort_done", 32'(done), 0);
    checkOutput("abort_sweeps", 32'(sweeps), 0);
    tick();
    checkOutput("abort_no_done", 32'(done), 0);
    applyStimulus(1, 0, 1);
    tick();
    applyStimulus(0, 0, 0);
    checkOutput("abort_start_idle", 32'(busy), 0);

    // Injected illegal step in UP
    $display("[TB] injected steps");
    doReset();
    cnt_run = 1'b0; inject = 1'b1;
    cnt_inj = 10'sd90;  applyStimulus(1, 0, 0); tick(); applyStimulus(0, 0, 0);
    cnt_inj = 10'sd95;  tick();
    cnt_inj = 10'sd100; tick();
    checkOutput("legal_up_no_err", 32'(err_step), 0);
    cnt_inj = 10'sd103; tick();
    checkOutput("bad_step_err", 32'(err_step), 1);
    cnt_inj = 10'sd108; tick();
    checkOutput("bad_step_sticky", 32'(err_step), 1);
    checkOutput("bad_step_busy", 32'(busy), 1);

    // Legal skip over -11 while counting up
    doReset();
    cnt_inj = -10'sd26; applyStimulus(1, 0, 0); tick(); applyStimulus(0, 0, 0);
    cnt_inj = -10'sd21; tick();
    cnt_inj = -10'sd16; tick();
    cnt_inj = -10'sd6;  tick();
    cnt_inj = -10'sd1;  tick();
    checkOutput("skip_up_no_err", 32'(err_step), 0);
    checkOutput("skip_up_busy", 32'(busy), 1);

    // Legal skip over -11 while counting down
    doReset();
    cnt_inj = 10'sd240; applyStimulus(1, 0, 0); tick(); applyStimulus(0, 0, 0);
    waitMode(1'b0, 20, n);
    checkOutput("inj_dwell_cycles", n, 5);
    cnt_inj = 10'sd7;   tick();
    cnt_inj = -10'sd2;  tick();
    cnt_inj = -10'sd20; tick();
    cnt_inj = -10'sd29; tick();
    checkOutput("skip_down_no_err", 32'(err_step), 0);
    checkOutput("skip_down_busy", 32'(busy), 1);

    // Stall: cnt held at 50 in UP
    doReset();
    cnt_inj = 10'sd50; applyStimulus(1, 0, 0); tick(); applyStimulus(0, 0, 0);
    repeat (7) tick();
    checkOutput("stall_not_yet", 32'(err_stall), 0);
    checkOutput("stall_not_yet_busy", 32'(busy), 1);
    tick();
    checkOutput("stall_err", 32'(err_stall), 1);
    checkOutput("stall_idle", 32'(busy), 0);
    checkOutput("stall_mode", 32'(mode), 1);

    // Forbidden value seen while idle
    doReset();
    cnt_inj = -10'sd11; tick();
    checkOutput("forbidden_value", 32'(err_step), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sweep_mode_ctrl.md
Name: sweep_mode_ctrl

Overview:
- Upstream controller for the signed 10-bit up/down counter.
- Drives the counter's `mode` input (1 = count up +5, 0 = count down −9) and watches the counter's `cnt` output as feedback.
- Runs repeated triangle sweeps: up to the top saturation band, dwell, down to the bottom band, dwell, repeat.
- Also flags illegal counter steps and stalled counting.

Parameters:
- HI_THR, 231, cnt ≥ HI_THR means the top saturation band has been reached.
- LO_THR, -222, cnt ≤ LO_THR means the bottom saturation band has been reached.
- DWELL, 4, cycles spent in each dwell state (≥1).
- NUM_SWEEPS, 0, number of full sweeps before returning to IDLE; 0 = unlimited.
- STALL_MAX, 8, number of consecutive unchanged-cnt cycles in UP/DOWN that counts as a stall.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin sweeping; ignored unless in IDLE
- stop  in  1  graceful stop request; takes effect at the end of the current DWELL_LO
- abort  in  1  immediate return to IDLE
- cnt  in  signed 10  counter output (feedback)
- mode  out  1  registered; drives the counter's mode input
- busy  out  1  high in any state except IDLE
- sweeps  out  8  completed sweeps; saturates at 255; cleared on start
- done  out  1  one-cycle pulse when a graceful stop or NUM_SWEEPS completion reaches IDLE
- err_step  out  1  sticky; illegal counter delta seen
- err_stall  out  1  sticky; stall detected

Behaviour:
- Reset values:
  - state = IDLE, mode = 1, busy = 0, sweeps = 0, done = 0, err_step = 0, err_stall = 0.
  - Internal: stop_pend = 0, dwell_cnt = 0, stall_cnt = 0, cnt_q = −50, chk_v = 0.
- All outputs are registered.
  - A transition decided at edge t is visible on mode/busy after t.
  - The counter applies that mode at edge t+1, so the cnt response appears one cycle after mode.
- States:
  - IDLE: mode holds its last value; busy = 0.
    - start → UP, mode ← 1. This clears sweeps, err_step, err_stall and stop_pend.
  - UP: mode = 1.
    - cnt ≥ HI_THR → DWELL_HI, dwell_cnt ← DWELL−1.
  - DWELL_HI: mode stays 1.
    - dwell_cnt decrements each cycle; at 0 → DOWN, mode ← 0.
  - DOWN: mode = 0.
    - cnt ≤ LO_THR → DWELL_LO, dwell_cnt ← DWELL−1.
  - DWELL_LO: mode stays 0.
    - At dwell_cnt = 0: sweeps increments (saturating).
    - Then, if stop_pend, or NUM_SWEEPS ≠ 0 and the new sweeps value = NUM_SWEEPS → IDLE, mode ← 1, done pulses.
    - Otherwise → UP, mode ← 1.
- stop:
  - Sets stop_pend in any non-IDLE state.
  - Has no immediate effect on state.
  - Ignored in IDLE.
- abort:
  - From any state → IDLE next cycle, mode ← 1, stop_pend cleared.
  - done is not pulsed.
  - abort has priority over start, stop and all FSM transitions.
  - abort and start in the same cycle while in IDLE: stay in IDLE.
- Step check:
  - cnt_q registers cnt every cycle; mode_q registers mode.
  - chk_v = 1 when the previous cycle's state was UP or DOWN.
  - The check applies when chk_v = 1 and LO_THR < cnt < HI_THR.
  - Legal deltas (cnt − cnt_q, computed at 11 bits signed): +5 or +10 when mode_q = 1; −9 or −18 when mode_q = 0.
  - The ±10 and −18 deltas are the legal skips over the forbidden value −11.
  - Any other delta sets err_step. err_step does not change state.
- Stall check:
  - In UP/DOWN, stall_cnt increments while cnt == cnt_q and resets on any change.
  - stall_cnt = STALL_MAX−1 with cnt unchanged → err_stall ← 1, state → IDLE, mode ← 1.
  - stall_cnt is cleared on any state change.
- cnt == −11 at any time sets err_step.
- rst mid-sweep: every register returns to its reset value the next cycle, irrespective of the other inputs.

Decomposition:
- Package sweep_pkg holds:
  - enum state_t {IDLE, UP, DWELL_HI, DOWN, DWELL_LO}
  - constants CNT_W = 10, STEP_UP = 5, STEP_DN = 9, CNT_INV = −11, CNT_RST = −50
  - type cnt_t = logic signed [CNT_W−1:0]
- One sub-module: sweep_step_chk, the combinational/registered delta legality check producing a one-cycle err pulse, which the top makes sticky.

Test Plan:
- Reset then start with DWELL = 4, counter attached (cnt from −50):
  - mode = 1 for 57 cnt steps until cnt = 235 → DWELL_HI for 4 cycles.
  - Then mode = 0; cnt reaches −224 after 51 down steps → DWELL_LO.
  - sweeps = 1, mode returns to 1.
- NUM_SWEEPS = 2: after the second DWELL_LO, IDLE with done high for exactly 1 cycle, sweeps = 2, busy = 0.
- stop asserted mid-UP on sweep 1:
  - FSM completes DOWN and DWELL_LO, then enters IDLE with done = 1, sweeps = 1.
  - abort mid-DOWN instead: IDLE next cycle, mode = 1, done = 0, sweeps unchanged.
- Injected cnt:
  - In UP, cnt_q = 100 → cnt = 103: err_step = 1 and stays set; FSM continues.
  - cnt_q = −16 → −6 in UP: no error.
  - cnt_q = −2 → −20 in DOWN: no error.
- Injected cnt held at 50 in UP with STALL_MAX = 8: err_stall rises on the 8th unchanged cycle, state = IDLE, mode = 1.
- rst asserted during DWELL_HI: all outputs return to reset values next cycle; a following start clears nothing extra and sweeps from UP.
